// File: rtl/boom_brkill_resp_queue.sv
// Branch-killable response FIFO between the dcache response mux and the LSU.
// Entries are killed in place (become holes) and holes drain one per cycle
// from the head without presenting deq_valid.

// One storage slot: occupancy/live state, branch mask tracking and payload.
module boom_brkill_resp_slot #(
  parameter int BR_W  = 12,
  parameter int PAY_W = 74
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             clr,
  input  logic [BR_W-1:0]  resolve,
  input  logic [BR_W-1:0]  mispredict,
  input  logic             flush,
  input  logic [BR_W-1:0]  wr_br_mask,
  input  logic             wr_uses_ldq,
  input  logic             wr_is_hella,
  input  logic [PAY_W-1:0] wr_pay,
  output logic             occupied,
  output logic             live,
  output logic             kill,
  output logic [BR_W-1:0]  br_mask,
  output logic             uses_ldq,
  output logic             is_hella,
  output logic [PAY_W-1:0] pay
);

  // Hella requests are immune; flush only kills loads.
  assign kill = live & ~is_hella & ((|(br_mask & mispredict)) | (flush & uses_ldq));

  // Write on enqueue, free on head advance, otherwise track resolves/kills.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occupied <= 1'b0;
      live     <= 1'b0;
      br_mask  <= '0;
      uses_ldq <= 1'b0;
      is_hella <= 1'b0;
      pay      <= '0;
    end else if (wr_en) begin
      occupied <= 1'b1;
      live     <= 1'b1;
      br_mask  <= wr_br_mask & ~resolve;
      uses_ldq <= wr_uses_ldq;
      is_hella <= wr_is_hella;
      pay      <= wr_pay;
    end else if (clr) begin
      occupied <= 1'b0;
      live     <= 1'b0;
    end else begin
      br_mask <= br_mask & ~resolve;
      if (kill) live <= 1'b0;
    end
  end

endmodule

module boom_brkill_resp_queue #(
  parameter  int DEPTH  = 8,
  parameter  int BR_W   = 12,
  parameter  int IDX_W  = 5,
  parameter  int DATA_W = 64,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [BR_W-1:0]   enq_br_mask,
  input  logic [IDX_W-1:0]  enq_ldq_idx,
  input  logic [IDX_W-1:0]  enq_stq_idx,
  input  logic              enq_uses_ldq,
  input  logic              enq_is_hella,
  input  logic [DATA_W-1:0] enq_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [BR_W-1:0]   deq_br_mask,
  output logic [IDX_W-1:0]  deq_ldq_idx,
  output logic [IDX_W-1:0]  deq_stq_idx,
  output logic              deq_uses_ldq,
  output logic              deq_is_hella,
  output logic [DATA_W-1:0] deq_data,
  input  logic [BR_W-1:0]   brupdate_resolve_mask,
  input  logic [BR_W-1:0]   brupdate_mispredict_mask,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  typedef struct packed {
    logic [IDX_W-1:0]  ldq_idx;
    logic [IDX_W-1:0]  stq_idx;
    logic [DATA_W-1:0] data;
  } pay_t;

  localparam int PAY_W = $bits(pay_t);

  logic [PTR_W-1:0] head, tail, head_nxt, tail_nxt;
  logic             maybe_full, full;
  logic             enq_kill, do_enq, head_ok, head_adv;

  logic [DEPTH-1:0]            occ, live, kill, uses, hella;
  logic [DEPTH-1:0][BR_W-1:0]  br;
  logic [DEPTH-1:0][PAY_W-1:0] pay;
  pay_t                        wr_pay, head_pay;

  assign full      = (head == tail) & maybe_full;
  assign enq_ready = ~full;

  assign enq_kill = ~enq_is_hella &
                    ((|(enq_br_mask & brupdate_mispredict_mask)) | (flush & enq_uses_ldq));
  assign do_enq   = enq_valid & enq_ready & ~enq_kill;
  assign wr_pay   = '{ldq_idx: enq_ldq_idx, stq_idx: enq_stq_idx, data: enq_data};

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slot
      boom_brkill_resp_slot #(.BR_W(BR_W), .PAY_W(PAY_W)) u_slot (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_en       (do_enq & (tail == PTR_W'(g))),
        .clr         (head_adv & (head == PTR_W'(g))),
        .resolve     (brupdate_resolve_mask),
        .mispredict  (brupdate_mispredict_mask),
        .flush       (flush),
        .wr_br_mask  (enq_br_mask),
        .wr_uses_ldq (enq_uses_ldq),
        .wr_is_hella (enq_is_hella),
        .wr_pay      (wr_pay),
        .occupied    (occ[g]),
        .live        (live[g]),
        .kill        (kill[g]),
        .br_mask     (br[g]),
        .uses_ldq    (uses[g]),
        .is_hella    (hella[g]),
        .pay         (pay[g])
      );
    end
  endgenerate

  // Head is presented only if live and not killed this very cycle;
  // any occupied-but-dead head is a hole and drains on its own.
  assign head_ok      = occ[head] & live[head] & ~kill[head];
  assign head_adv     = (head_ok & deq_ready) | (occ[head] & ~head_ok);
  assign head_pay     = pay_t'(pay[head]);
  assign deq_valid    = head_ok;
  assign deq_br_mask  = br[head] & ~brupdate_resolve_mask;
  assign deq_ldq_idx  = head_pay.ldq_idx;
  assign deq_stq_idx  = head_pay.stq_idx;
  assign deq_uses_ldq = uses[head];
  assign deq_is_hella = hella[head];
  assign deq_data     = head_pay.data;

  assign head_nxt = (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
  assign tail_nxt = (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;

  // Pointer and full-flag update; simultaneous enq and head advance keep maybe_full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head       <= '0;
      tail       <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq)   tail <= tail_nxt;
      if (head_adv) head <= head_nxt;
      if (do_enq && !head_adv && (tail_nxt == head)) maybe_full <= 1'b1;
      else if (head_adv && !do_enq)                  maybe_full <= 1'b0;
    end
  end

  // Occupancy including holes; handles non-power-of-two wrap.
  always_comb begin
    if (full)              count = CNT_W'(DEPTH);
    else if (tail >= head) count = CNT_W'(tail) - CNT_W'(head);
    else                   count = CNT_W'(DEPTH) + CNT_W'(tail) - CNT_W'(head);
  end

endmodule

// File: tb/tb_boom_brkill_resp_queue.sv
// Directed bench for boom_brkill_resp_queue (DEPTH=8, BR_W=12, IDX_W=5, DATA_W=64).
module tb_boom_brkill_resp_queue;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [11:0] enq_br_mask = '0;
  logic [4:0]  enq_ldq_idx = '0;
  logic [4:0]  enq_stq_idx = '0;
  logic        enq_uses_ldq = 1'b0;
  logic        enq_is_hella = 1'b0;
  logic [63:0] enq_data = '0;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [11:0] deq_br_mask;
  logic [4:0]  deq_ldq_idx, deq_stq_idx;
  logic        deq_uses_ldq, deq_is_hella;
  logic [63:0] deq_data;
  logic [11:0] resolve = '0;
  logic [11:0] mispredict = '0;
  logic        flush = 1'b0;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  boom_brkill_resp_queue #(.DEPTH(8), .BR_W(12), .IDX_W(5), .DATA_W(64)) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .enq_valid                (enq_valid),
    .enq_ready                (enq_ready),
    .enq_br_mask              (enq_br_mask),
    .enq_ldq_idx              (enq_ldq_idx),
    .enq_stq_idx              (enq_stq_idx),
    .enq_uses_ldq             (enq_uses_ldq),
    .enq_is_hella             (enq_is_hella),
    .enq_data                 (enq_data),
    .deq_valid                (deq_valid),
    .deq_ready                (deq_ready),
    .deq_br_mask              (deq_br_mask),
    .deq_ldq_idx              (deq_ldq_idx),
    .deq_stq_idx              (deq_stq_idx),
    .deq_uses_ldq             (deq_uses_ldq),
    .deq_is_hella             (deq_is_hella),
    .deq_data                 (deq_data),
    .brupdate_resolve_mask    (resolve),
    .brupdate_mispredict_mask (mispredict),
    .flush                    (flush),
    .count                    (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic enq(input logic [11:0] br, input logic uses, input logic hella,
                     input logic [63:0] data, input logic [4:0] idx);
    enq_valid    = 1'b1;
    enq_br_mask  = br;
    enq_uses_ldq = uses;
    enq_is_hella = hella;
    enq_data     = data;
    enq_ldq_idx  = idx;
    enq_stq_idx  = ~idx;
  endtask

  task automatic no_enq();
    enq_valid    = 1'b0;
    enq_br_mask  = '0;
    enq_uses_ldq = 1'b0;
    enq_is_hella = 1'b0;
  endtask

  initial begin
    // reset state
    settle();
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // 1: three live entries stream through with one-cycle latency
    deq_ready = 1'b1;
    enq(12'h0, 1'b1, 1'b0, 64'hA, 5'd1);
    settle();
    chk("t1_empty_deq_valid", 64'(deq_valid), 64'd0);
    tick();
    enq(12'h0, 1'b1, 1'b0, 64'hB, 5'd2);
    settle();
    chk("t1_deq_valid_a", 64'(deq_valid), 64'd1);
    chk("t1_data_a", deq_data, 64'hA);
    chk("t1_ldq_a", 64'(deq_ldq_idx), 64'd1);
    chk("t1_stq_a", 64'(deq_stq_idx), 64'd30);
    tick();
    enq(12'h0, 1'b1, 1'b0, 64'hC, 5'd3);
    settle();
    chk("t1_data_b", deq_data, 64'hB);
    tick();
    no_enq();
    settle();
    chk("t1_data_c", deq_data, 64'hC);
    chk("t1_count_c", 64'(count), 64'd1);
    tick();
    settle();
    chk("t1_count_end", 64'(count), 64'd0);
    chk("t1_valid_end", 64'(deq_valid), 64'd0);

    // 2: fill to 8, full blocks enq even while dequeuing, order kept across wrap
    deq_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      enq(12'h0, 1'b0, 1'b0, 64'h10 + 64'(i), 5'(i));
      tick();
    end
    no_enq();
    settle();
    chk("t2_full_count", 64'(count), 64'd8);
    chk("t2_full_enq_ready", 64'(enq_ready), 64'd0);
    deq_ready = 1'b1;
    enq(12'h0, 1'b0, 1'b0, 64'h99, 5'd9);
    settle();
    chk("t2_full_deq_enq_ready", 64'(enq_ready), 64'd0);
    chk("t2_head_data", deq_data, 64'h10);
    tick();
    no_enq();
    deq_ready = 1'b0;
    settle();
    chk("t2_enq_ready_after", 64'(enq_ready), 64'd1);
    chk("t2_count_after", 64'(count), 64'd7);
    deq_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      settle();
      chk("t2_order", deq_data, 64'h10 + 64'(i));
      tick();
    end
    settle();
    chk("t2_drained_count", 64'(count), 64'd0);
    chk("t2_drained_valid", 64'(deq_valid), 64'd0);

    // 3: mispredict turns head into a hole that drains silently
    deq_ready = 1'b0;
    enq(12'h001, 1'b1, 1'b0, 64'h31, 5'd4);
    tick();
    enq(12'h002, 1'b1, 1'b0, 64'h32, 5'd5);
    tick();
    no_enq();
    mispredict = 12'h001;
    settle();
    chk("t3_killed_valid", 64'(deq_valid), 64'd0);
    chk("t3_hole_count", 64'(count), 64'd2);
    tick();
    mispredict = '0;
    settle();
    chk("t3_second_valid", 64'(deq_valid), 64'd1);
    chk("t3_second_data", deq_data, 64'h32);
    chk("t3_second_br", 64'(deq_br_mask), 64'h002);
    chk("t3_count", 64'(count), 64'd1);
    deq_ready = 1'b1;
    tick();
    settle();
    chk("t3_empty", 64'(count), 64'd0);

    // 4: resolve clears mask combinationally; resolve+mispredict same bit kills
    deq_ready = 1'b0;
    enq(12'h004, 1'b1, 1'b0, 64'h41, 5'd6);
    tick();
    no_enq();
    resolve = 12'h004;
    settle();
    chk("t4_resolve_comb", 64'(deq_br_mask), 64'h000);
    tick();
    resolve = '0;
    settle();
    chk("t4_resolve_stored", 64'(deq_br_mask), 64'h000);
    chk("t4_data", deq_data, 64'h41);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    enq(12'h004, 1'b1, 1'b0, 64'h42, 5'd7);
    tick();
    no_enq();
    resolve    = 12'h004;
    mispredict = 12'h004;
    settle();
    chk("t4_kill_wins_valid", 64'(deq_valid), 64'd0);
    tick();
    resolve    = '0;
    mispredict = '0;
    settle();
    chk("t4_kill_count", 64'(count), 64'd0);
    chk("t4_kill_valid", 64'(deq_valid), 64'd0);

    // 5: flush kills only the non-hella load; a flushed enq is dropped
    enq(12'h0, 1'b1, 1'b0, 64'h51, 5'd8);
    tick();
    enq(12'h0, 1'b0, 1'b0, 64'h52, 5'd9);
    tick();
    enq(12'h0, 1'b1, 1'b1, 64'h53, 5'd10);
    tick();
    flush = 1'b1;
    enq(12'h0, 1'b1, 1'b0, 64'h54, 5'd11);
    settle();
    chk("t5_flush_enq_ready", 64'(enq_ready), 64'd1);
    chk("t5_flush_valid", 64'(deq_valid), 64'd0);
    chk("t5_flush_count", 64'(count), 64'd3);
    tick();
    flush = 1'b0;
    no_enq();
    settle();
    chk("t5_count_after", 64'(count), 64'd2);
    chk("t5_store_data", deq_data, 64'h52);
    chk("t5_store_uses", 64'(deq_uses_ldq), 64'd0);
    deq_ready = 1'b1;
    tick();
    settle();
    chk("t5_hella_data", deq_data, 64'h53);
    chk("t5_hella_flag", 64'(deq_is_hella), 64'd1);
    tick();
    settle();
    chk("t5_empty_count", 64'(count), 64'd0);
    chk("t5_empty_valid", 64'(deq_valid), 64'd0);

    // 6: asynchronous reset mid-stream discards contents
    deq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enq(12'h0, 1'b1, 1'b0, 64'h61 + 64'(i), 5'(i));
      tick();
    end
    no_enq();
    settle();
    chk("t6_count5", 64'(count), 64'd5);
    reset_n = 1'b0;
    settle();
    chk("t6_rst_valid", 64'(deq_valid), 64'd0);
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_enq_ready", 64'(enq_ready), 64'd1);
    tick();
    reset_n = 1'b1;
    tick();
    enq(12'h0, 1'b1, 1'b0, 64'h71, 5'd17);
    tick();
    no_enq();
    settle();
    chk("t6_new_valid", 64'(deq_valid), 64'd1);
    chk("t6_new_data", deq_data, 64'h71);
    chk("t6_new_ldq", 64'(deq_ldq_idx), 64'd17);
    chk("t6_new_count", 64'(count), 64'd1);
    deq_ready = 1'b1;
    tick();
    settle();
    chk("t6_final_count", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
